// File: rtl/serial_mag_compare.sv
// -----------------------------------------------------------------------------
// serial_mag_compare
//
// Multi-cycle magnitude comparator for two WIDTH-bit operands. The operands are
// captured on an accepted start and scanned DIGIT bits per cycle, most
// significant digit first. The scan stops at the first digit that differs, or
// after the last digit when the operands are equal. The result is reported as
// one-hot eq/lt/gt together with a one-cycle done pulse.
//
// Signed (two's-complement) compares invert the sign bit of both operands when
// they are captured. This maps them to offset-binary, so the scan itself is
// always an unsigned compare.
//
// Parameters
//   WIDTH        operand width in bits (>= 2)
//   DIGIT        bits compared per cycle; must divide WIDTH exactly
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        compare request, honoured only in IDLE or DONE
//   a, b         operands, captured on the accepted start edge
//   signed_mode  1 = two's-complement compare, 0 = unsigned; captured with a/b
//   busy         compare in progress
//   done         one-cycle pulse, eq/lt/gt valid
//   eq, lt, gt   one-hot result; held until the next accepted start
// -----------------------------------------------------------------------------
module serial_mag_compare #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_mag_compare: WIDTH must be >= 2 and divisible by DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   flip_s;
    logic [DIGIT-1:0]   a_dig_s;
    logic [DIGIT-1:0]   b_dig_s;
    logic               accept_s;

    // The operand registers shift left after each equal digit, so the digit
    // under test is always the top DIGIT bits; idx_r only counts digits left.
    assign a_dig_s  = a_r[WIDTH-1 -: DIGIT];
    assign b_dig_s  = b_r[WIDTH-1 -: DIGIT];
    assign flip_s   = signed_mode ? SIGN_FLIP : {WIDTH{1'b0}};
    assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // Control FSM: operand capture, digit scan and registered result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            gt      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        a_r     <= a ^ flip_s;
                        b_r     <= b ^ flip_s;
                        idx_r   <= IDX_TOP;
                        eq      <= 1'b0;
                        lt      <= 1'b0;
                        gt      <= 1'b0;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= ST_SCAN;
                    end else begin
                        // Results stay valid; only the done pulse ends.
                        done    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (a_dig_s > b_dig_s) begin
                        gt      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (a_dig_s < b_dig_s) begin
                        lt      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (idx_r == {IDX_W{1'b0}}) begin
                        eq      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                        a_r     <= a_r << DIGIT;
                        b_r     <= b_r << DIGIT;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
